el2_dec_trigger_seq: RTL and testbench

//  Parametrised decode-stage instruction-address trigger unit, successor of the 4-trigger combinational PC matcher.

---
 rtl/el2_pkg.sv | 41 ++++
 rtl/el2_trig_cmp.sv | 35 +++
 rtl/el2_dec_trigger_seq.sv | 135 +++++++++++++
 tb/tb_el2_dec_trigger_seq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/el2_pkg.sv
// el2_pkg
//   Shared types and constants for the decode-stage instruction-address
//   trigger unit.
//   - el2_trig_cfg_t : per-trigger configuration (select, execute, m, mode,
//                      chain, tdata2, count)
//   - TRIG_EQ/MASK/GE/LT : compare mode encodings
//   - trig_ignore_bits : bit-ignore vector for the masked (NAPOT-style) mode
package el2_pkg;

  localparam int TRIG_CNT_W = 8;

  localparam logic [1:0] TRIG_EQ   = 2'b00;
  localparam logic [1:0] TRIG_MASK = 2'b01;
  localparam logic [1:0] TRIG_GE   = 2'b10;
  localparam logic [1:0] TRIG_LT   = 2'b11;

  typedef struct packed {
    logic                  select;
    logic                  execute;
    logic                  m;
    logic [1:0]            mode;
    logic                  chain;
    logic [31:0]           tdata2;
    logic [TRIG_CNT_W-1:0] count;
  } el2_trig_cfg_t;

  // Bit k is ignored when every lower tdata2 bit is one. The empty prefix
  // counts as all ones, so bit 0 is always ignored.
  function automatic logic [31:0] trig_ignore_bits(input logic [31:0] tdata2);
    logic [31:0] ign;
    logic        ones;
    ign  = '0;
    ones = 1'b1;
    for (int k = 0; k < 32; k++) begin
      ign[k] = ones;
      ones   = ones & tdata2[k];
    end
    return ign;
  endfunction

endpackage

// File: rtl/el2_trig_cmp.sv
// el2_trig_cmp
//   Single-trigger address comparator, purely combinational.
//   Ports:
//     en     in  1   trigger enabled for the current decode instruction
//     mode   in  2   compare mode (TRIG_EQ/MASK/GE/LT)
//     tdata2 in  32  compare value
//     data   in  32  value under test
//     raw    out 1   en & compare result
module el2_trig_cmp
  import el2_pkg::*;
(
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [31:0] tdata2,
  input  logic [31:0] data,
  output logic        raw
);

  logic        cmp;
  logic [31:0] ign;

  always_comb begin
    cmp = 1'b0;
    ign = trig_ignore_bits(tdata2);
    case (mode)
      TRIG_EQ:   cmp = (data == tdata2);
      TRIG_MASK: cmp = (((data ^ tdata2) & ~ign) == 32'h0);
      TRIG_GE:   cmp = (data >= tdata2);
      TRIG_LT:   cmp = (data <  tdata2);
      default:   cmp = 1'b0;
    endcase
    raw = en & cmp;
  end

endmodule

// File: rtl/el2_dec_trigger_seq.sv
// el2_dec_trigger_seq
//   Decode-stage instruction-address trigger unit with chaining, per-group
//   hit counting and a registered D->X match vector.
//   Ports:
//     clk, rst                in   clock, synchronous active-high reset
//     trig_cfg[NUM_TRIG]      in   per-trigger configuration
//     cfg_wr                  in   load counter i from trig_cfg[i].count
//     dec_i0_valid_d          in   i0 valid in decode
//     dec_i0_pc_d             in   i0 PC [31:1]
//     dec_i0_stall_d          in   decode held
//     dec_tlu_flush           in   kill decode instruction
//     hit_clr                 in   clear sticky hit i
//     dec_i0_trigger_match_x  out  registered fire vector for instruction in X
//     trig_hit                out  sticky per-trigger hit status
module el2_dec_trigger_seq
  import el2_pkg::*;
#(
  parameter int NUM_TRIG = 4,
  parameter int CNT_W    = TRIG_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  el2_trig_cfg_t       trig_cfg [NUM_TRIG],
  input  logic [NUM_TRIG-1:0] cfg_wr,
  input  logic                dec_i0_valid_d,
  input  logic [31:1]         dec_i0_pc_d,
  input  logic                dec_i0_stall_d,
  input  logic                dec_tlu_flush,
  input  logic [NUM_TRIG-1:0] hit_clr,
  output logic [NUM_TRIG-1:0] dec_i0_trigger_match_x,
  output logic [NUM_TRIG-1:0] trig_hit
);

  localparam int IDX_W = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1;

  logic                adv;
  logic [NUM_TRIG-1:0] en;
  logic [31:0]         data [NUM_TRIG];
  logic [NUM_TRIG-1:0] raw;
  logic [NUM_TRIG-1:0] chain_eff;
  logic [NUM_TRIG-1:0] acc;
  logic [NUM_TRIG-1:0] grp_ok;
  logic [NUM_TRIG-1:0] is_head;
  logic [IDX_W-1:0]    head_idx [NUM_TRIG];
  logic [NUM_TRIG-1:0] fire;

  logic [CNT_W-1:0]    cnt_q [NUM_TRIG];
  logic [CNT_W-1:0]    cnt_d [NUM_TRIG];
  logic [NUM_TRIG-1:0] match_x_q, match_x_d;
  logic [NUM_TRIG-1:0] trig_hit_q, trig_hit_d;

  assign adv = dec_i0_valid_d & ~dec_i0_stall_d & ~dec_tlu_flush;

  for (genvar g = 0; g < NUM_TRIG; g++) begin : g_cmp
    assign en[g]   = trig_cfg[g].execute & trig_cfg[g].m & ~trig_cfg[g].select & dec_i0_valid_d;
    assign data[g] = {dec_i0_pc_d, trig_cfg[g].tdata2[0]};

    el2_trig_cmp u_cmp (
      .en     (en[g]),
      .mode   (trig_cfg[g].mode),
      .tdata2 (trig_cfg[g].tdata2),
      .data   (data[g]),
      .raw    (raw[g])
    );
  end

  // Chain groups: a forward pass ANDs raw along each group (acc is complete
  // at the group tail) and records the head index; a backward pass copies
  // the tail result to every member.
  always_comb begin
    chain_eff = '0;
    acc       = '0;
    grp_ok    = '0;
    is_head   = '0;
    for (int i = 0; i < NUM_TRIG; i++) head_idx[i] = '0;

    for (int i = 0; i < NUM_TRIG - 1; i++) chain_eff[i] = trig_cfg[i].chain;

    is_head[0] = 1'b1;
    acc[0]     = raw[0];
    for (int i = 1; i < NUM_TRIG; i++) begin
      if (!chain_eff[i-1]) begin
        is_head[i]  = 1'b1;
        head_idx[i] = IDX_W'(i);
        acc[i]      = raw[i];
      end else begin
        head_idx[i] = head_idx[i-1];
        acc[i]      = acc[i-1] & raw[i];
      end
    end

    grp_ok[NUM_TRIG-1] = acc[NUM_TRIG-1];
    for (int i = NUM_TRIG - 2; i >= 0; i--) begin
      grp_ok[i] = chain_eff[i] ? grp_ok[i+1] : acc[i];
    end
  end

  // Only the head counter of a group gates and counts. A counter at 0 or 1
  // lets the match through and reloads, so it never decrements past 1.
  always_comb begin
    fire = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      fire[i] = grp_ok[i] & (cnt_q[head_idx[i]] <= CNT_W'(1)) & ~cfg_wr[head_idx[i]];
    end

    for (int i = 0; i < NUM_TRIG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cfg_wr[i]) begin
        cnt_d[i] = CNT_W'(trig_cfg[i].count);
      end else if (is_head[i] && adv && grp_ok[i]) begin
        cnt_d[i] = (cnt_q[i] <= CNT_W'(1)) ? CNT_W'(trig_cfg[i].count)
                                            : cnt_q[i] - CNT_W'(1);
      end
    end

    match_x_d  = adv ? fire : '0;
    trig_hit_d = (trig_hit_q & ~hit_clr) | match_x_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_x_q  <= '0;
      trig_hit_q <= '0;
      for (int i = 0; i < NUM_TRIG; i++) cnt_q[i] <= '0;
    end else begin
      match_x_q  <= match_x_d;
      trig_hit_q <= trig_hit_d;
      for (int i = 0; i < NUM_TRIG; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign dec_i0_trigger_match_x = match_x_q;
  assign trig_hit               = trig_hit_q;

endmodule

// File: tb/tb_el2_dec_trigger_seq.sv
// tb_el2_dec_trigger_seq
//   Directed bench for el2_dec_trigger_seq (NUM_TRIG=4, CNT_W=8).
module tb_el2_dec_trigger_seq;
  import el2_pkg::*;

  logic          clk;
  logic          rst;
  el2_trig_cfg_t cfg [4];
  logic [3:0]    cfg_wr;
  logic          valid;
  logic [31:1]   pc;
  logic          stall;
  logic          flush;
  logic [3:0]    hit_clr;
  logic [3:0]    match_x;
  logic [3:0]    trig_hit;

  int tests_run;
  int tests_failed;

  el2_dec_trigger_seq #(.NUM_TRIG(4), .CNT_W(8)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .trig_cfg               (cfg),
    .cfg_wr                 (cfg_wr),
    .dec_i0_valid_d         (valid),
    .dec_i0_pc_d            (pc),
    .dec_i0_stall_d         (stall),
    .dec_tlu_flush          (flush),
    .hit_clr                (hit_clr),
    .dec_i0_trigger_match_x (match_x),
    .trig_hit               (trig_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < 4; i++) cfg[i] = '0;
  endtask

  task automatic set_trig(input int idx, input logic [1:0] mode, input logic [31:0] t2,
                          input logic ch, input logic [7:0] cnt);
    cfg[idx].select  = 1'b0;
    cfg[idx].execute = 1'b1;
    cfg[idx].m       = 1'b1;
    cfg[idx].mode    = mode;
    cfg[idx].chain   = ch;
    cfg[idx].tdata2  = t2;
    cfg[idx].count   = cnt;
  endtask

  task automatic drive(input logic [31:0] byte_pc, input logic v, input logic s, input logic f);
    pc    = byte_pc[31:1];
    valid = v;
    stall = s;
    flush = f;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h8000_0100, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tests_run++;
    if (match_x !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_match got=%b want=%b", match_x, 4'b0000);
    end
    tests_run++;
    if (trig_hit !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_hit got=%b want=%b", trig_hit, 4'b0000);
    end
    tests_run++;
    if (dut.cnt_q[0] !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_cnt got=%0d want=0", dut.cnt_q[0]);
    end
    rst = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_exact();
    clear_cfg();
    set_trig(0, TRIG_EQ, 32'h8000_0100, 1'b0, 8'd0);
    drive(32'h8000_0100, 1'b1, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (match_x !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL exact_hit got=%b want=%b", match_x, 4'b0001);
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (match_x !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL exact_one_cycle got=%b want=%b", match_x, 4'b0000);
    end
    tests_run++;
    if (trig_hit !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL exact_sticky got=%b want=%b", trig_hit, 4'b0001);
    end
    hit_clr = 4'b0001;
    tick();
    hit_clr = 4'b0000;
    tests_run++;
    if (trig_hit !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL exact_hit_clr got=%b want=%b", trig_hit, 4'b0000);
    end
    drive(32'h8000_0102, 1'b1, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (match_x !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL exact_miss got=%b want=%b", match_x, 4'b0000);
    end
    cfg[0].m = 1'b0;
    drive(32'h8000_0100, 1'b1, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (match_x !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL exact_m_off got=%b want=%b", match_x, 4'b0000);
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // tdata2=0x8000_00FF ignores bits 8..0; bit 9 and above must match.
  task automatic test_masked();
    logic [31:0] pcs [5];
    logic        exp [5];
    pcs = '{32'h8000_00A4, 32'h8000_0104, 32'h8000_0204, 32'h8000_0004, 32'h9000_00A4};
    exp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    clear_cfg();
    set_trig(0, TRIG_MASK, 32'h8000_00FF, 1'b0, 8'd0);
    for (int k = 0; k < 5; k++) begin
      drive(pcs[k], 1'b1, 1'b0, 1'b0);
      tick();
      tests_run++;
      if (match_x !== {3'b000, exp[k]}) begin
        tests_failed++;
        $display("[TB] FAIL masked_%0d pc=%h got=%b want=%b", k, pcs[k], match_x, {3'b000, exp[k]});
      end
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_chain();
    logic [31:0] pcs [5];
    logic [3:0]  exp [5];
    pcs = '{32'h0000_1800, 32'h0000_2800, 32'h0000_0800, 32'h0000_1000, 32'h0000_2000};
    exp = '{4'b0011, 4'b0000, 4'b0000, 4'b0011, 4'b0000};
    clear_cfg();
    set_trig(0, TRIG_GE, 32'h0000_1000, 1'b1, 8'd0);
    set_trig(1, TRIG_LT, 32'h0000_2000, 1'b0, 8'd0);
    for (int k = 0; k < 5; k++) begin
      drive(pcs[k], 1'b1, 1'b0, 1'b0);
      tick();
      tests_run++;
      if (match_x !== exp[k]) begin
        tests_failed++;
        $display("[TB] FAIL chain_%0d pc=%h got=%b want=%b", k, pcs[k], match_x, exp[k]);
      end
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_count();
    logic [7:0] exp_cnt [6];
    exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1};
    clear_cfg();
    set_trig(0, TRIG_EQ, 32'h8000_0100, 1'b0, 8'd3);
    cfg_wr = 4'b0001;
    tick();
    cfg_wr = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (dut.cnt_q[0] !== exp_cnt[k]) begin
        tests_failed++;
        $display("[TB] FAIL count_cnt_%0d got=%0d want=%0d", k, dut.cnt_q[0], exp_cnt[k]);
      end
      drive(32'h8000_0100, 1'b1, 1'b0, 1'b0);
      tick();
      tests_run++;
      if (match_x !== ((k == 2 || k == 5) ? 4'b0001 : 4'b0000)) begin
        tests_failed++;
        $display("[TB] FAIL count_fire_%0d got=%b want=%b", k, match_x,
                 ((k == 2 || k == 5) ? 4'b0001 : 4'b0000));
      end
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (dut.cnt_q[0] !== 8'd3) begin
      tests_failed++;
      $display("[TB] FAIL count_end got=%0d want=3", dut.cnt_q[0]);
    end
  endtask

  // Continues from test_count: trig0 EQ 0x8000_0100, count=3, counter at 3.
  task automatic test_stall_flush();
    drive(32'h8000_0100, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      tests_run++;
      if (match_x !== 4'b0000 || dut.cnt_q[0] !== 8'd3) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold_%0d got match=%b cnt=%0d want match=0000 cnt=3", k, match_x, dut.cnt_q[0]);
      end
    end
    drive(32'h8000_0100, 1'b1, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (match_x !== 4'b0000 || dut.cnt_q[0] !== 8'd2) begin
      tests_failed++;
      $display("[TB] FAIL stall_release got match=%b cnt=%0d want match=0000 cnt=2", match_x, dut.cnt_q[0]);
    end
    tick();
    drive(32'h8000_0100, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    tests_run++;
    if (match_x !== 4'b0000 || dut.cnt_q[0] !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL stall_armed got match=%b cnt=%0d want match=0000 cnt=1", match_x, dut.cnt_q[0]);
    end
    drive(32'h8000_0100, 1'b1, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (match_x !== 4'b0001 || dut.cnt_q[0] !== 8'd3) begin
      tests_failed++;
      $display("[TB] FAIL stall_fire got match=%b cnt=%0d want match=0001 cnt=3", match_x, dut.cnt_q[0]);
    end
    tick();
    tick();
    drive(32'h8000_0100, 1'b1, 1'b0, 1'b1);
    tick();
    tests_run++;
    if (match_x !== 4'b0000 || dut.cnt_q[0] !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL flush got match=%b cnt=%0d want match=0000 cnt=1", match_x, dut.cnt_q[0]);
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // Continues from test_stall_flush: counter at 1, trig_hit[0] set.
  task automatic test_boundaries();
    rst = 1'b1;
    drive(32'h8000_0100, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tests_run++;
    if (match_x !== 4'b0000 || trig_hit !== 4'b0000 || dut.cnt_q[0] !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid got match=%b hit=%b cnt=%0d want 0000 0000 0", match_x, trig_hit, dut.cnt_q[0]);
    end
    cfg[0].count = 8'd2;
    cfg_wr = 4'b0001;
    tick();
    cfg_wr = 4'b0000;
    tests_run++;
    if (match_x !== 4'b0000 || dut.cnt_q[0] !== 8'd2 || trig_hit !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL cfg_wr_match got match=%b cnt=%0d hit=%b want 0000 2 0000", match_x, dut.cnt_q[0], trig_hit);
    end
    tick();
    hit_clr = 4'b0001;
    tick();
    hit_clr = 4'b0000;
    tests_run++;
    if (match_x !== 4'b0001 || trig_hit !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL set_beats_clr got match=%b hit=%b want 0001 0001", match_x, trig_hit);
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    hit_clr = 4'b0001;
    tick();
    hit_clr = 4'b0000;
    tests_run++;
    if (trig_hit !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL clr_alone got=%b want=%b", trig_hit, 4'b0000);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clear_cfg();
    cfg_wr  = 4'b0000;
    hit_clr = 4'b0000;
    rst     = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0);

    test_reset();
    test_exact();
    test_masked();
    test_chain();
    test_count();
    test_stall_flush();
    test_boundaries();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
